// File: rtl/mario_velocity_pkg.sv
// Shared types and constants for the mario_velocity player physics stage.
package mario_velocity_pkg;

    localparam int VEL_W = 6;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } vstate_t;

    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_JUMP  = 8'h1A;
    localparam logic [7:0] KEY_RUN   = 8'h0E;

    // Horizontal speed pair seen from the direction being pushed:
    // fwd is the speed in the pushed direction, rev the opposing one.
    typedef struct packed {
        logic [VEL_W-1:0] fwd;
        logic [VEL_W-1:0] rev;
    } hpair_t;

endpackage

// File: rtl/mario_velocity_if.sv
// Keyboard/contact inputs and velocity outputs of the player physics stage.
interface mario_velocity_if;
    import mario_velocity_pkg::*;

    logic [7:0]       keycode;
    logic             grounded;
    logic             ceiling_hit;
    logic [VEL_W-1:0] Right_V;
    logic [VEL_W-1:0] Left_V;
    logic [VEL_W-1:0] Up_V;
    logic [VEL_W-1:0] Down_V;
    vstate_t          v_state;

    modport master (
        output keycode, grounded, ceiling_hit,
        input  Right_V, Left_V, Up_V, Down_V, v_state
    );

    modport slave (
        input  keycode, grounded, ceiling_hit,
        output Right_V, Left_V, Up_V, Down_V, v_state
    );

endinterface

// File: rtl/mario_velocity_frame_tick_sync.sv
// Brings the asynchronous frame clock into the Clk domain and emits a
// single-Clk tick on each of its rising edges.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    // sync_q[0..1]: two-flop synchroniser, sync_q[2]: previous synchronised level
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the raw frame clock through the synchroniser chain
    always_comb begin
        sync_d = {sync_q[1:0], frame_clk};
    end

    // Synchroniser and edge-history registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign tick = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/mario_velocity.sv
// Player physics: turns keycode and ground/ceiling contact into the four
// velocity magnitudes consumed by the collision stage, once per frame tick.
// Optional build macro RUN_BOOST_EN: KEY_RUN doubles acceleration and the
// horizontal speed ceiling in the current direction of motion.
module mario_velocity
    import mario_velocity_pkg::*;
#(
    parameter logic [VEL_W-1:0] H_ACCEL      = 6'd1,
    parameter logic [VEL_W-1:0] H_DECEL      = 6'd1,
    parameter logic [VEL_W-1:0] H_MAX        = 6'd3,
    parameter logic [VEL_W-1:0] JUMP_V       = 6'd8,
    parameter logic [VEL_W-1:0] JUMP_CUT     = 6'd3,
    parameter logic [VEL_W-1:0] MAX_FALL     = 6'd6,
    parameter logic [3:0]       GRAV_DIV     = 4'd4,
    parameter logic [VEL_W-1:0] GROUND_PRESS = 6'd1
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            frame_clk,
    mario_velocity_if.slave bus
);

    localparam logic [VEL_W-1:0] ONE = 6'd1;
`ifdef RUN_BOOST_EN
    localparam logic [VEL_W-1:0] RUN_ACCEL = H_ACCEL << 1;
    localparam logic [VEL_W-1:0] RUN_MAX   = H_MAX << 1;
`endif

    logic tick;

    frame_tick_sync u_tick (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .frame_clk(frame_clk),
        .tick     (tick)
    );

    logic [VEL_W-1:0] right_v_q, right_v_d, left_v_q, left_v_d;
    logic [VEL_W-1:0] up_v_q, up_v_d, down_v_q, down_v_d;
    vstate_t          state_q, state_d;
    logic             jump_armed_q, jump_armed_d;
    logic [3:0]       grav_cnt_q, grav_cnt_d, grav_nxt;
    logic             grav_step;

    function automatic logic [VEL_W-1:0] sat_add(input logic [VEL_W-1:0] a,
                                                 input logic [VEL_W-1:0] inc,
                                                 input logic [VEL_W-1:0] lim);
        logic [VEL_W:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return (sum > {1'b0, lim}) ? lim : sum[VEL_W-1:0];
    endfunction

    function automatic logic [VEL_W-1:0] sat_sub(input logic [VEL_W-1:0] a,
                                                 input logic [VEL_W-1:0] dec);
        return (a > dec) ? (a - dec) : '0;
    endfunction

    // Pushing one way first bleeds off opposing speed, then sheds any excess
    // left over from a run, then accelerates toward the ceiling.
    function automatic hpair_t drive_dir(input hpair_t cur,
                                         input logic [VEL_W-1:0] acc,
                                         input logic [VEL_W-1:0] lim);
        hpair_t r;
        r = cur;
        if (cur.rev != '0) begin
            r.rev = sat_sub(cur.rev, H_DECEL);
        end else if (cur.fwd > lim) begin
            r.fwd = sat_sub(cur.fwd, H_DECEL);
        end else begin
            r.fwd = sat_add(cur.fwd, acc, lim);
        end
        return r;
    endfunction

    // Horizontal accel/decel from the current keycode
    always_comb begin
        right_v_d = right_v_q;
        left_v_d  = left_v_q;
        if (tick) begin
            case (bus.keycode)
                KEY_RIGHT: {right_v_d, left_v_d} = drive_dir({right_v_q, left_v_q}, H_ACCEL, H_MAX);
                KEY_LEFT:  {left_v_d, right_v_d} = drive_dir({left_v_q, right_v_q}, H_ACCEL, H_MAX);
`ifdef RUN_BOOST_EN
                KEY_RUN: begin
                    if (right_v_q != '0) begin
                        {right_v_d, left_v_d} = drive_dir({right_v_q, left_v_q}, RUN_ACCEL, RUN_MAX);
                    end else if (left_v_q != '0) begin
                        {left_v_d, right_v_d} = drive_dir({left_v_q, right_v_q}, RUN_ACCEL, RUN_MAX);
                    end
                end
`endif
                default: begin
                    right_v_d = sat_sub(right_v_q, H_DECEL);
                    left_v_d  = sat_sub(left_v_q, H_DECEL);
                end
            endcase
        end
    end

    // Jump/fall state machine with frame-divided gravity and jump cut
    always_comb begin
        state_d      = state_q;
        up_v_d       = up_v_q;
        down_v_d     = down_v_q;
        jump_armed_d = jump_armed_q;
        grav_cnt_d   = grav_cnt_q;
        grav_nxt     = grav_cnt_q + 4'd1;
        grav_step    = (grav_nxt == GRAV_DIV);
        if (tick) begin
            if (bus.keycode != KEY_JUMP) begin
                jump_armed_d = 1'b1;
            end
            case (state_q)
                GROUND: begin
                    up_v_d   = '0;
                    down_v_d = GROUND_PRESS;
                    if (bus.keycode == KEY_JUMP && jump_armed_q) begin
                        state_d      = RISE;
                        up_v_d       = JUMP_V;
                        down_v_d     = '0;
                        jump_armed_d = 1'b0;
                    end else if (!bus.grounded) begin
                        state_d  = FALL;
                        down_v_d = '0;
                    end
                end
                RISE: begin
                    down_v_d = '0;
                    if (bus.ceiling_hit) begin
                        state_d = FALL;
                        up_v_d  = '0;
                    end else begin
                        // Gravity phase keeps running even on a jump-cut tick
                        grav_cnt_d = grav_step ? 4'd0 : grav_nxt;
                        if (bus.keycode != KEY_JUMP && up_v_q > JUMP_CUT) begin
                            up_v_d = JUMP_CUT;
                        end else if (grav_step) begin
                            up_v_d = sat_sub(up_v_q, ONE);
                            if (up_v_q <= ONE) begin
                                state_d = FALL;
                            end
                        end
                    end
                end
                FALL: begin
                    up_v_d = '0;
                    if (bus.grounded) begin
                        state_d  = GROUND;
                        down_v_d = GROUND_PRESS;
                    end else begin
                        grav_cnt_d = grav_step ? 4'd0 : grav_nxt;
                        if (grav_step) begin
                            down_v_d = sat_add(down_v_q, ONE, MAX_FALL);
                        end
                    end
                end
                default: begin
                    state_d  = FALL;
                    up_v_d   = '0;
                    down_v_d = '0;
                end
            endcase
            if (state_d != state_q) begin
                grav_cnt_d = '0;
            end
        end
    end

    // Horizontal speed registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            right_v_q <= '0;
            left_v_q  <= '0;
        end else begin
            right_v_q <= right_v_d;
            left_v_q  <= left_v_d;
        end
    end

    // Vertical state, speed, jump arming and gravity counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= FALL;
            up_v_q       <= '0;
            down_v_q     <= '0;
            jump_armed_q <= 1'b1;
            grav_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            up_v_q       <= up_v_d;
            down_v_q     <= down_v_d;
            jump_armed_q <= jump_armed_d;
            grav_cnt_q   <= grav_cnt_d;
        end
    end

    assign bus.Right_V = right_v_q;
    assign bus.Left_V  = left_v_q;
    assign bus.Up_V    = up_v_q;
    assign bus.Down_V  = down_v_q;
    assign bus.v_state = state_q;

endmodule

// File: tb/tb_mario_velocity.sv
// Bench for mario_velocity: directed scenarios followed by random keycode and
// contact traffic, all compared against a behavioural player-physics model.
module tb_mario_velocity;
    import mario_velocity_pkg::*;

`ifdef RUN_BOOST_EN
    localparam bit BOOST = 1'b1;
`else
    localparam bit BOOST = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset_n;
    logic frame_clk;

    mario_velocity_if vif ();

    mario_velocity dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .frame_clk(frame_clk),
        .bus      (vif)
    );

    always #10 Clk = ~Clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state: plain integers, time-in-state instead of a counter
    int      mr, ml, mu, md, tis;
    bit      marmed;
    vstate_t mst;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mr = 0; ml = 0; mu = 0; md = 0; tis = 0;
        marmed = 1'b1;
        mst = FALL;
    endtask

    // Speed in the pushed direction (f) and opposite direction (r)
    task automatic push(input int f_in, input int r_in, input int acc, input int lim,
                        output int f_out, output int r_out);
        f_out = f_in; r_out = r_in;
        if (r_in > 0)        r_out = imax(r_in - 1, 0);
        else if (f_in > lim) f_out = f_in - 1;
        else                 f_out = imin(f_in + acc, lim);
    endtask

    task automatic model_tick(input logic [7:0] kc, input logic g, input logic c);
        vstate_t nst;
        int a, b;
        // horizontal
        if (kc == 8'h07) begin
            push(mr, ml, 1, 3, a, b); mr = a; ml = b;
        end else if (kc == 8'h04) begin
            push(ml, mr, 1, 3, a, b); ml = a; mr = b;
        end else if (BOOST && kc == 8'h0E && mr > 0) begin
            push(mr, ml, 2, 6, a, b); mr = a; ml = b;
        end else if (BOOST && kc == 8'h0E && ml > 0) begin
            push(ml, mr, 2, 6, a, b); ml = a; mr = b;
        end else if (!(BOOST && kc == 8'h0E)) begin
            mr = imax(mr - 1, 0);
            ml = imax(ml - 1, 0);
        end
        // vertical
        if (kc != 8'h1A) marmed = 1'b1;
        nst = mst;
        if (mst == GROUND) begin
            mu = 0; md = 1;
            if (kc == 8'h1A && marmed) begin
                nst = RISE; mu = 8; md = 0; marmed = 1'b0;
            end else if (!g) begin
                nst = FALL; md = 0;
            end
        end else if (mst == RISE) begin
            md = 0;
            if (c) begin
                nst = FALL; mu = 0;
            end else begin
                tis++;
                if (kc != 8'h1A && mu > 3) mu = 3;
                else if (tis % 4 == 0) begin
                    mu = mu - 1;
                    if (mu == 0) nst = FALL;
                end
            end
        end else begin
            mu = 0;
            if (g) begin
                nst = GROUND; md = 1;
            end else begin
                tis++;
                if (tis % 4 == 0) md = imin(md + 1, 6);
            end
        end
        if (nst != mst) tis = 0;
        mst = nst;
    endtask

    task automatic compare_all(input string ph);
        check({ph, " Right_V"}, 32'(vif.Right_V), mr);
        check({ph, " Left_V"},  32'(vif.Left_V),  ml);
        check({ph, " Up_V"},    32'(vif.Up_V),    mu);
        check({ph, " Down_V"},  32'(vif.Down_V),  md);
        check({ph, " v_state"}, 32'(vif.v_state), 32'(mst));
        check({ph, " both_h_nonzero"}, 32'(vif.Right_V != '0 && vif.Left_V != '0), 0);
    endtask

    // One frame: raise frame_clk, expect no change until the third Clk edge
    task automatic apply_tick(input string ph, input logic [7:0] kc, input logic g, input logic c);
        @(negedge Clk);
        vif.keycode = kc; vif.grounded = g; vif.ceiling_hit = c;
        frame_clk = 1'b1;
        repeat (2) @(posedge Clk);
        #1 compare_all({ph, " pre"});
        @(posedge Clk);
        #1;
        model_tick(kc, g, c);
        compare_all(ph);
        @(negedge Clk) frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
    endtask

    task automatic async_reset(input string ph);
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        model_reset();
        check({ph, " Right_V"}, 32'(vif.Right_V), 0);
        check({ph, " Left_V"},  32'(vif.Left_V),  0);
        check({ph, " Up_V"},    32'(vif.Up_V),    0);
        check({ph, " Down_V"},  32'(vif.Down_V),  0);
        check({ph, " v_state"}, 32'(vif.v_state), 32'(FALL));
        @(negedge Clk) Reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dmax, rmax, guard;
        logic [7:0] kc;
        Reset_n = 1'b1;
        frame_clk = 1'b0;
        vif.keycode = 8'h00; vif.grounded = 1'b0; vif.ceiling_hit = 1'b0;
        model_reset();
        #5 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1 compare_all("reset");
        @(negedge Clk) Reset_n = 1'b1;

        // Right accelerates to the ceiling, then reverse through zero
        for (int i = 0; i < 5; i++) begin
            apply_tick("right", 8'h07, 1'b1, 1'b0);
            check("right seq", 32'(vif.Right_V), (i < 3) ? i + 1 : 3);
        end
        for (int i = 0; i < 4; i++) begin
            apply_tick("reverse", 8'h04, 1'b1, 1'b0);
            check("reverse Right_V", 32'(vif.Right_V), (i < 3) ? 2 - i : 0);
        end
        check("reverse Left_V", 32'(vif.Left_V), 1);
        apply_tick("idle", 8'h00, 1'b1, 1'b0);

        // Held jump: full arc, land, no re-jump while held
        for (int i = 0; i < 40; i++) begin
            apply_tick("jump_hold", 8'h1A, 1'b1, 1'b0);
            if (i == 0)  check("jump start Up_V", 32'(vif.Up_V), 8);
            if (i == 31) check("jump tick31 Up_V", 32'(vif.Up_V), 1);
            if (i == 32) check("jump tick32 v_state", 32'(vif.v_state), 32'(FALL));
            if (i == 39) check("no rejump v_state", 32'(vif.v_state), 32'(GROUND));
        end

        // Jump cut on release, then ceiling bonk
        apply_tick("rearm", 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) apply_tick("cut_rise", 8'h1A, 1'b1, 1'b0);
        check("before cut Up_V", 32'(vif.Up_V), 7);
        apply_tick("cut", 8'h00, 1'b1, 1'b0);
        check("cut Up_V", 32'(vif.Up_V), 3);
        guard = 0;
        while (mst != GROUND && guard < 30) begin
            apply_tick("land", 8'h00, 1'b1, 1'b0);
            guard++;
        end
        check("landed v_state", 32'(vif.v_state), 32'(GROUND));
        for (int i = 0; i < 13; i++) apply_tick("bonk_rise", 8'h1A, 1'b1, 1'b0);
        check("before bonk Up_V", 32'(vif.Up_V), 5);
        apply_tick("bonk", 8'h1A, 1'b1, 1'b1);
        check("bonk Up_V", 32'(vif.Up_V), 0);
        check("bonk v_state", 32'(vif.v_state), 32'(FALL));

        // Long fall saturates, then landing
        dmax = 0;
        for (int i = 0; i < 30; i++) begin
            apply_tick("fall", 8'h00, 1'b0, 1'b0);
            if (int'(vif.Down_V) > dmax) dmax = int'(vif.Down_V);
        end
        check("fall max Down_V", dmax, 6);
        check("fall end Down_V", 32'(vif.Down_V), 6);
        apply_tick("touchdown", 8'h00, 1'b1, 1'b0);
        check("touchdown Down_V", 32'(vif.Down_V), 1);
        check("touchdown v_state", 32'(vif.v_state), 32'(GROUND));

        // Run key
        rmax = 0;
        for (int i = 0; i < 4; i++) apply_tick("walk", 8'h07, 1'b1, 1'b0);
        check("walk Right_V", 32'(vif.Right_V), 3);
        for (int i = 0; i < 3; i++) begin
            apply_tick("run", 8'h0E, 1'b1, 1'b0);
            if (int'(vif.Right_V) > rmax) rmax = int'(vif.Right_V);
            if (i == 0) check("run first Right_V", 32'(vif.Right_V), BOOST ? 5 : 2);
        end
        check("run end Right_V", 32'(vif.Right_V), BOOST ? 6 : 0);
        for (int i = 0; i < 4; i++) begin
            apply_tick("unrun", 8'h07, 1'b1, 1'b0);
            if (int'(vif.Right_V) > rmax) rmax = int'(vif.Right_V);
        end
        check("unrun Right_V", 32'(vif.Right_V), 3);
        check("run peak Right_V", rmax, BOOST ? 6 : 3);

        // Reset mid-jump
        apply_tick("pre_mid", 8'h00, 1'b1, 1'b0);
        apply_tick("mid_jump", 8'h1A, 1'b1, 1'b0);
        apply_tick("mid_jump", 8'h1A, 1'b1, 1'b0);
        check("mid_jump v_state", 32'(vif.v_state), 32'(RISE));
        async_reset("reset_mid_jump");

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 6))
                0: kc = 8'h07;
                1: kc = 8'h04;
                2: kc = 8'h1A;
                3: kc = 8'h0E;
                4: kc = 8'h00;
                5: kc = 8'($urandom);
                default: kc = 8'h1A;
            endcase
            apply_tick("rand", kc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
            if (i % 150 == 149) async_reset("rand_reset");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
